// File: rtl/multi_mode_count_shifter.sv
// Iterative shifter for the FP adder: right shift with guard/round/sticky, left shift and
// normalise, moving up to STEP positions per clock and reporting the distance shifted.
module multi_mode_count_shifter #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 8,
  parameter int STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_data,
  input  logic [CNT_W-1:0] i_count,
  output logic [WIDTH-1:0] o_result,
  output logic             o_guard,
  output logic             o_round,
  output logic             o_sticky,
  output logic [CNT_W-1:0] o_shift_amt,
  output logic             o_busy,
  output logic             o_done
);

  localparam int XW = WIDTH + 2;
  localparam int CW = CNT_W + 32;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [XW-1:0]    r_val;
  logic             r_sticky;
  logic             r_left;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_amt;

  logic [CW-1:0]    w_cnt_ext;
  logic [CNT_W-1:0] w_lz;
  logic [CNT_W-1:0] w_lim_w;
  logic [CNT_W-1:0] w_n;
  logic [CNT_W-1:0] w_step;
  logic [XW-1:0]    w_shifted;
  logic [XW-1:0]    w_lost_mask;
  logic             w_lost;

  function automatic logic [CNT_W-1:0] lead_zeros(input logic [WIDTH-1:0] d);
    logic [CNT_W-1:0] lz;
    lz = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) lz = CNT_W'(WIDTH - 1 - i);
    end
    return lz;
  endfunction

  // Effective shift amount; normalise is capped by the leading-zero count up front so the
  // shift loop can never push a set bit past the MSB.
  always_comb begin
    w_cnt_ext = CW'(i_count);
    w_lz      = lead_zeros(i_data);
    w_lim_w   = (w_cnt_ext > CW'(WIDTH)) ? CNT_W'(WIDTH) : i_count;
    w_n       = '0;
    case (i_mode)
      2'b01:   w_n = w_lim_w;
      2'b10:   w_n = (w_lz < w_lim_w) ? w_lz : w_lim_w;
      default: w_n = (w_cnt_ext > CW'(XW)) ? CNT_W'(XW) : i_count;
    endcase
  end

  always_comb begin
    w_step      = (r_rem < CNT_W'(STEP)) ? r_rem : CNT_W'(STEP);
    w_shifted   = r_left ? (r_val << w_step) : (r_val >> w_step);
    w_lost_mask = ~({XW{1'b1}} << w_step);
    w_lost      = ~r_left & (|(r_val & w_lost_mask));
  end

  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = (w_n == '0) ? S_FINISH : S_SHIFT;
      S_SHIFT:  if (r_rem == w_step) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // The two bits below the operand hold guard and round; in left modes they only ever see zeros.
  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear) begin
      r_val    <= '0;
      r_sticky <= 1'b0;
      r_left   <= 1'b0;
      r_rem    <= '0;
      r_amt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_val    <= {i_data, 2'b00};
            r_sticky <= 1'b0;
            r_left   <= (i_mode == 2'b01) || (i_mode == 2'b10);
            r_rem    <= w_n;
            r_amt    <= '0;
          end
        end
        S_SHIFT: begin
          r_val    <= w_shifted;
          r_sticky <= r_sticky | w_lost;
          r_rem    <= r_rem - w_step;
          r_amt    <= r_amt + w_step;
        end
        default: ;
      endcase
    end
  end

  assign o_result    = r_val[XW-1:2];
  assign o_guard     = r_val[1];
  assign o_round     = r_val[0];
  assign o_sticky    = r_sticky;
  assign o_shift_amt = r_amt;
  assign o_busy      = (r_state == S_SHIFT);
  assign o_done      = (r_state == S_FINISH);

endmodule

// File: tb/tb_multi_mode_count_shifter.sv
// Directed bench for multi_mode_count_shifter with one STEP=1 and one STEP=4 instance
// sharing clock, reset and operand inputs.
module tb_multi_mode_count_shifter;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        selFour = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [23:0] data = '0;
  logic [7:0]  count = '0;

  logic [23:0] res1, res4;
  logic        g1, g4, r1, r4, s1, s4, busy1, busy4, done1, done4;
  logic [7:0]  amt1, amt4;

  logic [23:0] result;
  logic        guard, round, sticky, busy, done;
  logic [7:0]  shiftAmt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_mode_count_shifter #(.WIDTH(24), .CNT_W(8), .STEP(1)) uStep1 (
    .i_clk(clk), .i_clear(clear), .i_start(start & ~selFour), .i_mode(mode),
    .i_data(data), .i_count(count), .o_result(res1), .o_guard(g1), .o_round(r1),
    .o_sticky(s1), .o_shift_amt(amt1), .o_busy(busy1), .o_done(done1));

  multi_mode_count_shifter #(.WIDTH(24), .CNT_W(8), .STEP(4)) uStep4 (
    .i_clk(clk), .i_clear(clear), .i_start(start & selFour), .i_mode(mode),
    .i_data(data), .i_count(count), .o_result(res4), .o_guard(g4), .o_round(r4),
    .o_sticky(s4), .o_shift_amt(amt4), .o_busy(busy4), .o_done(done4));

  assign result   = selFour ? res4  : res1;
  assign guard    = selFour ? g4    : g1;
  assign round    = selFour ? r4    : r1;
  assign sticky   = selFour ? s4    : s1;
  assign shiftAmt = selFour ? amt4  : amt1;
  assign busy     = selFour ? busy4 : busy1;
  assign done     = selFour ? done4 : done1;

  // Launch one operation and return the Done latency (edges after acceptance) and outputs.
  task automatic do_op(input bit useFour, input logic [1:0] m, input logic [23:0] d,
                       input logic [7:0] c, output int lat, output logic [39:0] obs);
    @(negedge clk);
    selFour = useFour; mode = m; data = d; count = c; start = 1'b1;
    @(posedge clk);
    lat = 0;
    obs = 'x;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = cyc;
        obs = {result, guard, round, sticky, shiftAmt};
        break;
      end
    end
    if (lat == 0) begin
      errors++; checks++;
      $display("[TB] FAIL op_timeout: got no done within 200 cycles, expected a done pulse");
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({res1, g1, r1, s1, amt1, busy1, done1} !== 42'h0) begin
      errors++;
      $display("[TB] FAIL reset_step1: got %h expected 0", {res1, g1, r1, s1, amt1, busy1, done1});
    end
    checks++;
    if ({res4, g4, r4, s4, amt4, busy4, done4} !== 42'h0) begin
      errors++;
      $display("[TB] FAIL reset_step4: got %h expected 0", {res4, g4, r4, s4, amt4, busy4, done4});
    end
    @(negedge clk); @(negedge clk);
    clear = 1'b1;
  endtask

  task automatic test_right;
    int lat;
    logic [39:0] obs;
    do_op(1'b0, 2'b00, 24'h800001, 8'd3, lat, obs);
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL right1_latency: got %0d expected 4", lat); end
    checks++;
    if (obs !== {24'h100000, 3'b001, 8'd3}) begin
      errors++; $display("[TB] FAIL right1_outputs: got %h expected %h", obs, {24'h100000, 3'b001, 8'd3});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL right1_done_width: got %b expected 0", done); end
    checks++;
    if ({result, guard, round, sticky, shiftAmt} !== obs) begin
      errors++; $display("[TB] FAIL right1_hold: got %h expected %h", {result, guard, round, sticky, shiftAmt}, obs);
    end

    do_op(1'b1, 2'b00, 24'hFFFFFF, 8'd30, lat, obs);
    checks++;
    if (lat !== 8) begin errors++; $display("[TB] FAIL right2_latency: got %0d expected 8", lat); end
    checks++;
    if (obs !== {24'h000000, 3'b001, 8'd26}) begin
      errors++; $display("[TB] FAIL right2_outputs: got %h expected %h", obs, {24'h000000, 3'b001, 8'd26});
    end

    do_op(1'b0, 2'b11, 24'h000007, 8'd1, lat, obs);
    checks++;
    if (lat !== 2) begin errors++; $display("[TB] FAIL right3_latency: got %0d expected 2", lat); end
    checks++;
    if (obs !== {24'h000003, 3'b100, 8'd1}) begin
      errors++; $display("[TB] FAIL right3_outputs: got %h expected %h", obs, {24'h000003, 3'b100, 8'd1});
    end

    do_op(1'b1, 2'b00, 24'h000001, 8'd200, lat, obs);
    checks++;
    if (lat !== 8) begin errors++; $display("[TB] FAIL right4_latency: got %0d expected 8", lat); end
    checks++;
    if (obs !== {24'h000000, 3'b001, 8'd26}) begin
      errors++; $display("[TB] FAIL right4_outputs: got %h expected %h", obs, {24'h000000, 3'b001, 8'd26});
    end
  endtask

  task automatic test_left;
    int lat;
    logic [39:0] obs;
    do_op(1'b1, 2'b01, 24'h000001, 8'd23, lat, obs);
    checks++;
    if (lat !== 7) begin errors++; $display("[TB] FAIL left1_latency: got %0d expected 7", lat); end
    checks++;
    if (obs !== {24'h800000, 3'b000, 8'd23}) begin
      errors++; $display("[TB] FAIL left1_outputs: got %h expected %h", obs, {24'h800000, 3'b000, 8'd23});
    end

    do_op(1'b0, 2'b01, 24'hABCDEF, 8'd40, lat, obs);
    checks++;
    if (lat !== 25) begin errors++; $display("[TB] FAIL left2_latency: got %0d expected 25", lat); end
    checks++;
    if (obs !== {24'h000000, 3'b000, 8'd24}) begin
      errors++; $display("[TB] FAIL left2_outputs: got %h expected %h", obs, {24'h000000, 3'b000, 8'd24});
    end
  endtask

  task automatic test_normalise;
    int lat;
    logic [39:0] obs;
    do_op(1'b0, 2'b10, 24'h000F00, 8'd31, lat, obs);
    checks++;
    if (lat !== 13) begin errors++; $display("[TB] FAIL norm1_latency: got %0d expected 13", lat); end
    checks++;
    if (obs !== {24'hF00000, 3'b000, 8'd12}) begin
      errors++; $display("[TB] FAIL norm1_outputs: got %h expected %h", obs, {24'hF00000, 3'b000, 8'd12});
    end

    do_op(1'b1, 2'b10, 24'h000000, 8'd31, lat, obs);
    checks++;
    if (lat !== 7) begin errors++; $display("[TB] FAIL norm2_latency: got %0d expected 7", lat); end
    checks++;
    if (obs !== {24'h000000, 3'b000, 8'd24}) begin
      errors++; $display("[TB] FAIL norm2_outputs: got %h expected %h", obs, {24'h000000, 3'b000, 8'd24});
    end

    do_op(1'b1, 2'b10, 24'h800000, 8'd5, lat, obs);
    checks++;
    if (lat !== 1) begin errors++; $display("[TB] FAIL norm3_latency: got %0d expected 1", lat); end
    checks++;
    if (obs !== {24'h800000, 3'b000, 8'd0}) begin
      errors++; $display("[TB] FAIL norm3_outputs: got %h expected %h", obs, {24'h800000, 3'b000, 8'd0});
    end

    do_op(1'b1, 2'b10, 24'h000F00, 8'd5, lat, obs);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL norm4_latency: got %0d expected 3", lat); end
    checks++;
    if (obs !== {24'h01E000, 3'b000, 8'd5}) begin
      errors++; $display("[TB] FAIL norm4_outputs: got %h expected %h", obs, {24'h01E000, 3'b000, 8'd5});
    end
  endtask

  task automatic test_zero_count;
    int lat;
    logic [39:0] obs;
    do_op(1'b0, 2'b00, 24'h123456, 8'd0, lat, obs);
    checks++;
    if (lat !== 1) begin errors++; $display("[TB] FAIL zero1_latency: got %0d expected 1", lat); end
    checks++;
    if (obs !== {24'h123456, 3'b000, 8'd0}) begin
      errors++; $display("[TB] FAIL zero1_outputs: got %h expected %h", obs, {24'h123456, 3'b000, 8'd0});
    end

    do_op(1'b1, 2'b01, 24'h654321, 8'd0, lat, obs);
    checks++;
    if (lat !== 1) begin errors++; $display("[TB] FAIL zero2_latency: got %0d expected 1", lat); end
    checks++;
    if (obs !== {24'h654321, 3'b000, 8'd0}) begin
      errors++; $display("[TB] FAIL zero2_outputs: got %h expected %h", obs, {24'h654321, 3'b000, 8'd0});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [39:0] obs;
    @(negedge clk);
    selFour = 1'b0; mode = 2'b00; data = 24'h0000FF; count = 8'd9; start = 1'b1;
    @(posedge clk);
    lat = 0;
    obs = 'x;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
        mode = 2'b01; data = 24'h123456; count = 8'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = cyc;
        obs = {result, guard, round, sticky, shiftAmt};
        break;
      end
    end
    checks++;
    if (lat !== 10) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 10", lat); end
    checks++;
    if (obs !== {24'h000000, 3'b011, 8'd9}) begin
      errors++; $display("[TB] FAIL b2b_outputs: got %h expected %h", obs, {24'h000000, 3'b011, 8'd9});
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_no_restart: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_mid_reset;
    int lat;
    logic [39:0] obs;
    bit sawDone;
    @(negedge clk);
    selFour = 1'b0; mode = 2'b00; data = 24'h0000FF; count = 8'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_before: got %b expected 1", busy); end
    clear = 1'b0;
    #1;
    checks++;
    if ({res1, g1, r1, s1, amt1, busy1, done1} !== 42'h0) begin
      errors++; $display("[TB] FAIL abort_outputs: got %h expected 0", {res1, g1, r1, s1, amt1, busy1, done1});
    end
    sawDone = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (done1) sawDone = 1'b1;
    end
    clear = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done1) sawDone = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done: got %b expected 0", sawDone); end

    do_op(1'b0, 2'b00, 24'h800001, 8'd3, lat, obs);
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL after_reset_latency: got %0d expected 4", lat); end
    checks++;
    if (obs !== {24'h100000, 3'b001, 8'd3}) begin
      errors++; $display("[TB] FAIL after_reset_outputs: got %h expected %h", obs, {24'h100000, 3'b001, 8'd3});
    end
  endtask

  initial begin
    test_reset();
    test_right();
    test_left();
    test_normalise();
    test_zero_count();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
